// File: rtl/dsp_mac_sequencer_if.sv
// Wishbone master-side bus bundle between the MAC sequencer and the
// 25x16 multiply-accumulate slave.
interface dsp_mac_sequencer_if;
    logic        m_cyc;
    logic        m_stb;
    logic        m_we;
    logic [31:0] m_adr;
    logic [31:0] m_dat_mosi;
    logic [31:0] m_dat_miso;
    logic        m_ack;

    modport master (
        output m_cyc,
        output m_stb,
        output m_we,
        output m_adr,
        output m_dat_mosi,
        input  m_dat_miso,
        input  m_ack
    );

    modport slave (
        input  m_cyc,
        input  m_stb,
        input  m_we,
        input  m_adr,
        input  m_dat_mosi,
        output m_dat_miso,
        output m_ack
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: buffers (a,b) operand pairs, then drives the 25x16 MAC
// slave over Wishbone (base snapshot, write A, write B, accumulate per pair,
// end snapshot) and reports the per-job accumulator delta.
module dsp_mac_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [24:0]            in_a,
    input  logic [15:0]            in_b,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [47:0]            result,
    output logic                   result_valid,
    output logic [$clog2(DEPTH):0] fifo_count,
    dsp_mac_sequencer_if.master    wb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // Slave register map (byte addresses).
    localparam logic [31:0] ADR_A    = 32'h0000_0000;
    localparam logic [31:0] ADR_B    = 32'h0000_0004;
    localparam logic [31:0] ADR_P_LO = 32'h0000_0008;
    localparam logic [31:0] ADR_P_HI = 32'h0000_000C;
    localparam logic [31:0] ADR_ACC  = 32'h0000_0010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } state_e;

    typedef enum logic [2:0] {
        OP_RD_BASE_LO,
        OP_RD_BASE_HI,
        OP_WR_A,
        OP_WR_B,
        OP_ACC,
        OP_RD_END_LO,
        OP_RD_END_HI
    } op_e;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } bus_req_t;

    // Address, direction and write data for one bus op; reads carry zero data.
    function automatic bus_req_t op_fields(input op_e o, input logic [24:0] a,
                                           input logic [15:0] b);
        bus_req_t r;
        r.adr = ADR_P_LO;
        r.we  = 1'b0;
        r.dat = 32'h0;
        case (o)
            OP_RD_BASE_LO, OP_RD_END_LO: r.adr = ADR_P_LO;
            OP_RD_BASE_HI, OP_RD_END_HI: r.adr = ADR_P_HI;
            OP_WR_A: begin
                r.adr = ADR_A;
                r.we  = 1'b1;
                r.dat = {7'b0, a};
            end
            OP_WR_B: begin
                r.adr = ADR_B;
                r.we  = 1'b1;
                r.dat = {16'b0, b};
            end
            OP_ACC:  r.adr = ADR_ACC;
            default: r.adr = ADR_P_LO;
        endcase
        return r;
    endfunction

    state_e           state;
    op_e              op;
    op_e              next_op;
    bus_req_t         issue_req;
    logic [CNT_W-1:0] pairs_left;
    logic [TMO_W-1:0] tmo_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [24:0]      mem_a [DEPTH];
    logic [15:0]      mem_b [DEPTH];
    logic [24:0]      head_a;
    logic [15:0]      head_b;
    logic [31:0]      base_lo;
    logic [15:0]      base_hi;
    logic [31:0]      end_lo;
    logic             push;
    logic             unused_miso_hi;

    // The slave's upper read-data half carries nothing the sequencer needs.
    assign unused_miso_hi = &{1'b0, wb.m_dat_miso[31:16]};

    // Held in reset so nothing is accepted while the block is being cleared.
    assign in_ready = !wb_rst_i && !busy && (fifo_count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head_a   = mem_a[rd_ptr];
    assign head_b   = mem_b[rd_ptr];

    // Next bus op once the current one is acknowledged.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        next_op = op;
        case (op)
            OP_RD_BASE_LO: next_op = OP_RD_BASE_HI;
            OP_RD_BASE_HI: next_op = (pairs_left != '0) ? OP_WR_A : OP_RD_END_LO;
            OP_WR_A:       next_op = OP_WR_B;
            OP_WR_B:       next_op = OP_ACC;
            OP_ACC:        next_op = (pairs_left > CNT_W'(1)) ? OP_WR_A : OP_RD_END_LO;
            OP_RD_END_LO:  next_op = OP_RD_END_HI;
            default:       next_op = op;
        endcase
    end

    // Bus fields to drive on the next ISSUE: the first op when idle, else the pending op.
    always_comb begin
        issue_req = op_fields((state == S_IDLE) ? OP_RD_BASE_LO : op, head_a, head_b);
    end

    // Operand storage; write-only on push, read through the head pointer.
    // NOTE: the storage array has no reset -- emptiness is tracked by the pointers and count.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // Job sequencer: FIFO bookkeeping, Wishbone issue/ack/gap and result capture.
    // NOTE: all sequential state is assigned with <= so every update sees pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= S_IDLE;
            op            <= OP_RD_BASE_LO;
            pairs_left    <= '0;
            tmo_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            base_lo       <= '0;
            base_hi       <= '0;
            end_lo        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            result        <= '0;
            result_valid  <= 1'b0;
            wb.m_cyc      <= 1'b0;
            wb.m_stb      <= 1'b0;
            wb.m_we       <= 1'b0;
            wb.m_adr      <= '0;
            wb.m_dat_mosi <= '0;
        end else begin
            done <= 1'b0;

            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                fifo_count <= fifo_count + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        // A same-cycle push belongs to this job.
                        pairs_left    <= fifo_count + CNT_W'(push);
                        error         <= 1'b0;
                        result_valid  <= 1'b0;
                        busy          <= 1'b1;
                        op            <= OP_RD_BASE_LO;
                        tmo_cnt       <= '0;
                        wb.m_cyc      <= 1'b1;
                        wb.m_stb      <= 1'b1;
                        wb.m_we       <= issue_req.we;
                        wb.m_adr      <= issue_req.adr;
                        wb.m_dat_mosi <= issue_req.dat;
                        state         <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (wb.m_ack) begin
                        wb.m_cyc <= 1'b0;
                        wb.m_stb <= 1'b0;
                        tmo_cnt  <= '0;
                        case (op)
                            OP_RD_BASE_LO: base_lo <= wb.m_dat_miso;
                            OP_RD_BASE_HI: base_hi <= wb.m_dat_miso[15:0];
                            OP_ACC: begin
                                rd_ptr     <= rd_ptr + PTR_W'(1);
                                fifo_count <= fifo_count - CNT_W'(1);
                                pairs_left <= pairs_left - CNT_W'(1);
                            end
                            OP_RD_END_LO:  end_lo <= wb.m_dat_miso;
                            default: ;
                        endcase
                        if (op == OP_RD_END_HI) begin
                            // Wraps mod 2^48 exactly like the slave's accumulator.
                            result       <= {wb.m_dat_miso[15:0], end_lo} - {base_hi, base_lo};
                            result_valid <= 1'b1;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            op    <= next_op;
                            state <= S_GAP;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        // Slave never answered: abandon the job and drop the buffered pairs.
                        wb.m_cyc   <= 1'b0;
                        wb.m_stb   <= 1'b0;
                        tmo_cnt    <= '0;
                        error      <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        rd_ptr     <= wr_ptr;
                        fifo_count <= '0;
                        pairs_left <= '0;
                        state      <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_GAP: begin
                    // One idle cycle between ops so each ACC read accumulates exactly once.
                    wb.m_cyc      <= 1'b1;
                    wb.m_stb      <= 1'b1;
                    wb.m_we       <= issue_req.we;
                    wb.m_adr      <= issue_req.adr;
                    wb.m_dat_mosi <= issue_req.dat;
                    state         <= S_ISSUE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer: random operand jobs against a
// dot-product reference, a bus-trace scoreboard and a small Wishbone MAC slave.
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] adr;
        bit          we;
        logic [31:0] dat;
        int          cyc;
    } bus_exp_t;

    typedef struct {
        logic [47:0] res;
        int          done_cyc;
        bit          err;
    } job_exp_t;

    typedef struct {
        logic [24:0] a;
        logic [15:0] b;
    } pair_t;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [24:0]   in_a = '0;
    logic [15:0]   in_b = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [47:0]   result;
    logic          result_valid;
    logic [CW-1:0] fifo_count;

    dsp_mac_sequencer_if bus ();

    dsp_mac_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .result       (result),
        .result_valid (result_valid),
        .fifo_count   (fifo_count),
        .wb           (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int       cyc = 0;
    int       n_checks = 0;
    int       n_pass = 0;
    bus_exp_t bus_q[$];
    job_exp_t job_q[$];
    pair_t    pairs_q[$];
    bit       slave_mute = 1'b0;
    logic     stb_q = 1'b0;
    int       stb_run = 0;

    // Slave accumulator starts near the top of its range so jobs exercise the wrap.
    logic [47:0] slv_p = 48'hFFFF_FFFF_F000;
    logic [24:0] slv_a = '0;
    logic [15:0] slv_b = '0;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // MAC slave model: one transfer per ack; P is never reset.
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bus.m_ack      <= 1'b0;
            bus.m_dat_miso <= 32'h0;
        end else begin
            bus.m_ack <= 1'b0;
            if (bus.m_cyc && bus.m_stb && !bus.m_ack && !slave_mute) begin
                bus.m_ack      <= 1'b1;
                bus.m_dat_miso <= 32'h0;
                if (bus.m_we) begin
                    if (bus.m_adr == 32'h00) slv_a <= bus.m_dat_mosi[24:0];
                    else if (bus.m_adr == 32'h04) slv_b <= bus.m_dat_mosi[15:0];
                end else begin
                    case (bus.m_adr)
                        32'h08: bus.m_dat_miso <= slv_p[31:0];
                        32'h0C: bus.m_dat_miso <= {16'hA5A5, slv_p[47:32]};
                        32'h10: begin
                            slv_p          <= slv_p + 48'(slv_a) * 48'(slv_b);
                            bus.m_dat_miso <= 32'h1234_5678;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT starts a bus op or ends a job.
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            stb_q   <= 1'b0;
            stb_run <= 0;
        end else begin
            stb_q   <= bus.m_stb;
            stb_run <= bus.m_stb ? stb_run + 1 : 0;
            if (bus.m_stb && !stb_q) begin
                check("bus_op_expected", 64'(bus_q.size() != 0), 64'd1);
                if (bus_q.size() != 0) begin
                    bus_exp_t e;
                    e = bus_q.pop_front();
                    check("op_adr", bus.m_adr, e.adr);
                    check("op_we", bus.m_we, e.we);
                    check("op_dat", bus.m_dat_mosi, e.dat);
                    check("op_cyc_line", bus.m_cyc, 1);
                    check("op_start_cycle", cyc, e.cyc);
                end
            end
            if (stb_q && !bus.m_stb)
                check("stb_high_len", stb_run, slave_mute ? TIMEOUT : 2);
            if (busy) check("in_ready_low_busy", in_ready, 0);
            if (done) begin
                check("done_expected", 64'(job_q.size() != 0), 64'd1);
                if (job_q.size() != 0) begin
                    job_exp_t j;
                    j = job_q.pop_front();
                    check("done_cycle", cyc, j.done_cyc);
                    check("error", error, j.err);
                    check("result_valid", result_valid, !j.err);
                    if (!j.err) check("result", result, j.res);
                    check("busy_at_done", busy, 0);
                    check("fifo_empty_at_done", fifo_count, 0);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_m_cyc"}, bus.m_cyc, 0);
        check({tag, "_m_stb"}, bus.m_stb, 0);
        check({tag, "_m_we"}, bus.m_we, 0);
        check({tag, "_m_adr"}, bus.m_adr, 0);
        check({tag, "_m_dat_mosi"}, bus.m_dat_mosi, 0);
    endtask

    // Called at posedge+1; leaves at the next posedge+1 with in_valid low.
    task automatic push_pair(input logic [24:0] a, input logic [15:0] b);
        bit exp_ready;
        exp_ready = pairs_q.size() < DEPTH;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        #1;
        check("in_ready", in_ready, exp_ready);
        if (exp_ready) pairs_q.push_back('{a: a, b: b});
        @(posedge wb_clk_i);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_op(input logic [31:0] adr, input bit we, input logic [31:0] dat, input int c);
        bus_q.push_back('{adr: adr, we: we, dat: dat, cyc: c});
    endtask

    task automatic wait_done(input bit poke);
        int n;
        n = 0;
        while (job_q.size() != 0 && n < 400) begin
            start = poke && (n == 3);
            @(posedge wb_clk_i);
            #1;
            n++;
        end
        start = 1'b0;
        check("job_completed", job_q.size(), 0);
        check("bus_ops_drained", bus_q.size(), 0);
        job_q.delete();
        bus_q.delete();
    endtask

    // Expected trace and result come from the operand list alone: M = 4 + 3N ops,
    // op k starts at t+1+3k, done at t+3M, result = sum(a*b) mod 2^48.
    task automatic start_job(input bit mute, input bit same_push, input logic [24:0] a,
                             input logic [15:0] b, input bit wait_end, input bit poke);
        int          t;
        int          k;
        logic [47:0] sum;
        check("fifo_count_pre", fifo_count, pairs_q.size());
        slave_mute = mute;
        if (same_push && pairs_q.size() < DEPTH) begin
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            pairs_q.push_back('{a: a, b: b});
        end
        start = 1'b1;
        t     = cyc;
        k     = 0;
        sum   = '0;
        push_op(32'h08, 1'b0, 32'h0, t + 1 + 3 * k); k++;
        if (mute) begin
            job_q.push_back('{res: '0, done_cyc: t + 1 + TIMEOUT, err: 1'b1});
        end else begin
            push_op(32'h0C, 1'b0, 32'h0, t + 1 + 3 * k); k++;
            foreach (pairs_q[i]) begin
                push_op(32'h00, 1'b1, {7'b0, pairs_q[i].a}, t + 1 + 3 * k); k++;
                push_op(32'h04, 1'b1, {16'b0, pairs_q[i].b}, t + 1 + 3 * k); k++;
                push_op(32'h10, 1'b0, 32'h0, t + 1 + 3 * k); k++;
                sum = sum + 48'(pairs_q[i].a) * 48'(pairs_q[i].b);
            end
            push_op(32'h08, 1'b0, 32'h0, t + 1 + 3 * k); k++;
            push_op(32'h0C, 1'b0, 32'h0, t + 1 + 3 * k); k++;
            job_q.push_back('{res: sum, done_cyc: t + 3 * k, err: 1'b0});
        end
        pairs_q.delete();
        @(posedge wb_clk_i);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_start", busy, 1);
        check("error_cleared", error, 0);
        check("result_valid_cleared", result_valid, 0);
        if (wait_end) wait_done(poke);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [24:0] ra;
        logic [15:0] rb;
        int          n;

        // Asynchronous reset takes effect without a clock edge.
        #1 wb_rst_i = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        #1 check("in_ready_after_reset", in_ready, 1);
        @(posedge wb_clk_i);
        #1;

        // Single pair: done at t+21, result 15.
        push_pair(25'd3, 16'd5);
        start_job(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Two pairs including the maximum operands.
        push_pair(25'd2, 16'd7);
        push_pair(25'h1FF_FFFF, 16'hFFFF);
        start_job(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Repeat with a nonzero slave accumulator.
        push_pair(25'd3, 16'd5);
        start_job(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Empty job, with a start pulse while busy that must be ignored.
        start_job(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);

        // Overfill: the ninth push is refused.
        for (int i = 0; i < DEPTH + 1; i++) push_pair(25'($urandom()), 16'($urandom()));
        check("fifo_full_count", fifo_count, DEPTH);
        check("in_ready_full", in_ready, 0);
        start_job(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Random jobs, some with a push in the start cycle.
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(0, DEPTH));
            for (int i = 0; i < n; i++) begin
                ra = ($urandom_range(0, 3) == 0) ? 25'h1FF_FFFF : 25'($urandom());
                rb = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
                push_pair(ra, rb);
            end
            start_job(1'b0, (n < DEPTH) && ($urandom_range(0, 1) == 1),
                      25'($urandom()), 16'($urandom()), 1'b1, r == 2);
        end

        // Timeout: slave never acks.
        push_pair(25'd11, 16'd13);
        push_pair(25'd17, 16'd19);
        start_job(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        slave_mute = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("error_sticky", error, 1);
        check("result_valid_after_abort", result_valid, 0);
        check("fifo_flushed", fifo_count, 0);
        start_job(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Reset mid-job, after the accumulate has reached the slave.
        push_pair(25'd3, 16'd5);
        start_job(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (14) @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1 check_outputs_zero("mid_job_reset");
        job_q.delete();
        bus_q.delete();
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;

        // The base snapshot cancels the discarded job's product.
        push_pair(25'd3, 16'd5);
        start_job(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
